data_pack: RTL and testbench
============================

DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 SHALL have parameter HDR_MAGIC, default 16'h55AA, first two header bytes (MSB first).
REQ-002 SHALL have parameter BUF_SPAN, default 16'h0800, address offset between ping and pong TX buffers.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fs_pack  input  1  start request from control.
REQ-006 SHALL have port fd_pack  output  1  packet-complete flag.
REQ-007 SHALL have port btype  input  4  packet type, sampled at start.
REQ-008 SHALL have port data_idx  input  4  cache slot index, sampled at start.
REQ-009 SHALL have port cache_info  input  96  twelve 8-bit slot word-counts; slot n at bits [8n+7:8n].
REQ-010 SHALL have port cache_rxa  output  14  cache read address.
REQ-011 SHALL have port cache_rxd  input  8  cache read data, valid one cycle after cache_rxa.
REQ-012 SHALL have port ram_txa  output  16  TX RAM write address.
REQ-013 SHALL have port ram_txd  output  8  TX RAM write data.
REQ-014 SHALL have port ram_txen  output  1  TX RAM write enable.
REQ-015 SHALL have port tx_addr_init  output  16  base address of last completed packet.
REQ-016 SHALL have port tx_dlen  output  16  byte length of last completed packet.

Function
REQ-017 SHALL run FSM IDLE, HEAD, PRIME, BODY, TAIL, DONE.
REQ-018 IDLE: fs_pack=1 SHALL latch btype, data_idx, plen and go to HEAD next cycle.
REQ-019 plen SHALL equal {cache_info slot byte, 2'b00} (0..1020 bytes); data_idx>11 SHALL give plen=0.
REQ-020 HEAD SHALL write 8 bytes, one per cycle, ram_txen=1: magic hi, magic lo, {btype,data_idx}, plen[15:8], plen[7:0], seq, 8'h00, 8'h00.
REQ-021 Write address SHALL be buf_base+offset, buf_base = 0 or BUF_SPAN, offset 0 at first header byte, +1 per write.
REQ-022 PRIME SHALL drive cache_rxa={data_idx,10'd0}, ram_txen=0, one cycle; if plen=0 SHALL skip BODY to TAIL.
REQ-023 BODY SHALL increment cache_rxa each cycle and write cache_rxd each cycle, plen writes total, no bubbles.
REQ-024 TAIL SHALL write one byte: XOR of all header and payload bytes.
REQ-025 On TAIL exit SHALL set tx_addr_init=buf_base, tx_dlen=plen+9, seq+=1 (8-bit wrap 255->0), toggle buf_base, enter DONE.
REQ-026 DONE SHALL hold fd_pack=1 until fs_pack=0, then return to IDLE with fd_pack=0 the following cycle.
REQ-027 fs_pack held high in IDLE after DONE SHALL NOT restart; a new packet SHALL require fs_pack low for at least one cycle.
REQ-028 btype/data_idx/cache_info changes after start SHALL NOT affect the packet in progress.
REQ-029 ram_txen SHALL be 0 in IDLE, PRIME, DONE; ram_txa/ram_txd SHALL hold last value when not writing.
REQ-030 Start-to-fd_pack latency SHALL be exactly plen+11 cycles (fs_pack sampled to fd_pack high).

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, fd_pack=0, ram_txen=0, ram_txa=0, ram_txd=0, cache_rxa=0, tx_addr_init=0, tx_dlen=0, seq=0, buf_base=0.
REQ-032 Reset mid-packet SHALL abort without updating tx_addr_init/tx_dlen; next packet SHALL start at seq 0, buffer 0.

Verification
REQ-033 data_idx=2, slot2 count=1, btype=3, ramp cache data -> header 55 AA 32 00 04 00 00 00, 4 payload bytes, XOR tail, tx_dlen=13, tx_addr_init=0, fd_pack at cycle 15.
REQ-034 Two back-to-back packets -> second at base 0x0800, seq byte 01; third back at 0x0000, seq 02.
REQ-035 Slot count 0 and data_idx=13 -> 9-byte packet, no PRIME-to-BODY, tx_dlen=9, tail = XOR of header only.
REQ-036 Slot count 255 -> 1020 contiguous payload writes, cache_rxa ends at {idx,10'd1019}, tx_dlen=1029.
REQ-037 rst pulsed during BODY -> all outputs zero same cycle, tx_dlen unchanged at 0, subsequent packet seq 00 at base 0.
REQ-038 fs_pack held high 10 cycles past fd_pack -> no second packet; fd_pack stays 1 until fs_pack falls.

Source files
------------

// File: rtl/data_pack.sv
`default_nettype none
// ============================================================================
// data_pack - builds magic/type/len/seq header + cache payload + XOR tail into
// alternating ping/pong TX RAM buffers.                        Revision: 1.0
// ============================================================================
module data_pack #(
  parameter logic [15:0] HDR_MAGIC = 16'h55AA,
  parameter logic [15:0] BUF_SPAN  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_pack,
  output logic        fd_pack,
  input  logic [3:0]  btype,
  input  logic [3:0]  data_idx,
  input  logic [95:0] cache_info,
  output logic [13:0] cache_rxa,
  input  logic [7:0]  cache_rxd,
  output logic [15:0] ram_txa,
  output logic [7:0]  ram_txd,
  output logic        ram_txen,
  output logic [15:0] tx_addr_init,
  output logic [15:0] tx_dlen
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_PRIME = 3'd2,
    S_BODY  = 3'd3,
    S_TAIL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  btype_q;
  logic [3:0]  idx_q;
  logic [15:0] plen_q;
  logic [15:0] off_q, off_d;
  logic [13:0] rxa_q, rxa_d;
  logic [7:0]  cs_q, cs_d;
  logic [7:0]  seq_q, seq_d;
  logic        base_q, base_d;
  logic [15:0] addr_init_q, addr_init_d;
  logic [15:0] dlen_q, dlen_d;
  logic [15:0] txa_q;
  logic [7:0]  txd_q;

  logic [7:0]  w_slot;
  logic [15:0] w_plen;
  logic        w_start;
  logic [15:0] w_base_addr;
  logic [7:0]  w_hdr_byte;
  logic        w_rxa_more;
  logic        w_wr_en;
  logic [7:0]  w_wr_data;

  // Slot indices 12..15 have no word count and yield an empty payload.
  always_comb begin
    w_slot = 8'h00;
    for (int n = 0; n < 12; n++) begin
      if (data_idx == 4'(n)) begin
        w_slot = cache_info[8*n +: 8];
      end
    end
  end

  assign w_plen      = {6'd0, w_slot, 2'b00};
  assign w_start     = (state_q == S_IDLE) && fs_pack;
  assign w_base_addr = base_q ? BUF_SPAN : 16'h0000;
  // Stop advancing once the last payload address has been presented.
  assign w_rxa_more  = (({6'd0, rxa_q[9:0]}) + 16'd1) < plen_q;

  always_comb begin
    case (off_q[2:0])
      3'd0:    w_hdr_byte = HDR_MAGIC[15:8];
      3'd1:    w_hdr_byte = HDR_MAGIC[7:0];
      3'd2:    w_hdr_byte = {btype_q, idx_q};
      3'd3:    w_hdr_byte = plen_q[15:8];
      3'd4:    w_hdr_byte = plen_q[7:0];
      3'd5:    w_hdr_byte = seq_q;
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    rxa_d       = rxa_q;
    cs_d        = cs_q;
    seq_d       = seq_q;
    base_d      = base_q;
    addr_init_d = addr_init_q;
    dlen_d      = dlen_q;
    w_wr_en     = 1'b0;
    w_wr_data   = txd_q;

    case (state_q)
      S_IDLE: begin
        if (fs_pack) begin
          state_d = S_HEAD;
          off_d   = 16'd0;
          cs_d    = 8'h00;
        end
      end
      S_HEAD: begin
        w_wr_en   = 1'b1;
        w_wr_data = w_hdr_byte;
        cs_d      = cs_q ^ w_hdr_byte;
        off_d     = off_q + 16'd1;
        if (off_q == 16'd7) begin
          state_d = S_PRIME;
          rxa_d   = {idx_q, 10'd0};
        end
      end
      S_PRIME: begin
        state_d = (plen_q == 16'd0) ? S_TAIL : S_BODY;
        if (w_rxa_more) begin
          rxa_d = rxa_q + 14'd1;
        end
      end
      S_BODY: begin
        // Payload passes straight from the cache read port so the first byte
        // lands in the cycle right after PRIME without an extra pipeline stage.
        w_wr_en   = 1'b1;
        w_wr_data = cache_rxd;
        cs_d      = cs_q ^ cache_rxd;
        off_d     = off_q + 16'd1;
        if (w_rxa_more) begin
          rxa_d = rxa_q + 14'd1;
        end
        if (off_q == (plen_q + 16'd7)) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        w_wr_en     = 1'b1;
        w_wr_data   = cs_q;
        addr_init_d = w_base_addr;
        dlen_d      = plen_q + 16'd9;
        seq_d       = seq_q + 8'd1;
        base_d      = ~base_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (!fs_pack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fd_pack      = (state_q == S_DONE);
  assign ram_txen     = w_wr_en;
  assign ram_txd      = w_wr_data;
  assign ram_txa      = w_wr_en ? (w_base_addr + off_q) : txa_q;
  assign cache_rxa    = rxa_q;
  assign tx_addr_init = addr_init_q;
  assign tx_dlen      = dlen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      btype_q     <= 4'd0;
      idx_q       <= 4'd0;
      plen_q      <= 16'd0;
      off_q       <= 16'd0;
      rxa_q       <= 14'd0;
      cs_q        <= 8'h00;
      seq_q       <= 8'h00;
      base_q      <= 1'b0;
      addr_init_q <= 16'd0;
      dlen_q      <= 16'd0;
      txa_q       <= 16'd0;
      txd_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      rxa_q       <= rxa_d;
      cs_q        <= cs_d;
      seq_q       <= seq_d;
      base_q      <= base_d;
      addr_init_q <= addr_init_d;
      dlen_q      <= dlen_d;
      if (w_start) begin
        btype_q <= btype;
        idx_q   <= data_idx;
        plen_q  <= w_plen;
      end
      if (w_wr_en) begin
        txa_q <= ram_txa;
        txd_q <= w_wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_pack.sv
`default_nettype none
// tb_data_pack - random/directed packets checked against a byte-list packet model.
module tb_data_pack;

  localparam logic [15:0] C_MAGIC = 16'h55AA;
  localparam logic [15:0] C_SPAN  = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_pack;
  logic        fd_pack;
  logic [3:0]  btype;
  logic [3:0]  data_idx;
  logic [95:0] cache_info;
  logic [13:0] cache_rxa;
  logic [7:0]  cache_rxd;
  logic [15:0] ram_txa;
  logic [7:0]  ram_txd;
  logic        ram_txen;
  logic [15:0] tx_addr_init;
  logic [15:0] tx_dlen;

  data_pack #(.HDR_MAGIC(C_MAGIC), .BUF_SPAN(C_SPAN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fs_pack      (fs_pack),
    .fd_pack      (fd_pack),
    .btype        (btype),
    .data_idx     (data_idx),
    .cache_info   (cache_info),
    .cache_rxa    (cache_rxa),
    .cache_rxd    (cache_rxd),
    .ram_txa      (ram_txa),
    .ram_txd      (ram_txd),
    .ram_txen     (ram_txen),
    .tx_addr_init (tx_addr_init),
    .tx_dlen      (tx_dlen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous cache: data valid one cycle after the address.
  logic [7:0] mem [16384];
  always @(posedge clk) cache_rxd <= mem[cache_rxa];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          t;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) begin
    wr_t w;
    if (ram_txen === 1'b1) begin
      w.a = ram_txa;
      w.d = ram_txd;
      w.t = cyc;
      wq.push_back(w);
    end
  end

  int checks = 0;
  int fails  = 0;
  int exp_seq  = 0;
  int exp_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_plen(input logic [95:0] info, input logic [3:0] idx);
    if (idx > 4'd11) return 0;
    return 4 * int'(info[int'(idx)*8 +: 8]);
  endfunction

  function automatic logic [95:0] rand_info(input int maxc);
    logic [95:0] r;
    for (int n = 0; n < 12; n++) r[8*n +: 8] = 8'($urandom_range(0, maxc));
    return r;
  endfunction

  task automatic run_pkt(input string tag, input logic [3:0] bt, input logic [3:0] idx,
                         input int hold);
    int          plen, s, t_fd, nbad, first_bad, hold_bad, nwr;
    logic [15:0] p16, base;
    logic [13:0] erxa;
    logic [7:0]  x;
    logic [7:0]  exp_b[$];
    bit          seen;

    plen = slot_plen(cache_info, idx);
    p16  = 16'(plen);
    base = (exp_base != 0) ? C_SPAN : 16'h0000;
    exp_b = {};
    exp_b.push_back(C_MAGIC[15:8]);
    exp_b.push_back(C_MAGIC[7:0]);
    exp_b.push_back({bt, idx});
    exp_b.push_back(p16[15:8]);
    exp_b.push_back(p16[7:0]);
    exp_b.push_back(8'(exp_seq));
    exp_b.push_back(8'h00);
    exp_b.push_back(8'h00);
    for (int k = 0; k < plen; k++) exp_b.push_back(mem[{idx, 10'(k)}]);
    x = 8'h00;
    foreach (exp_b[i]) x ^= exp_b[i];
    exp_b.push_back(x);

    @(negedge clk);
    btype = bt; data_idx = idx; fs_pack = 1'b1;
    wq.delete();
    s = cyc;
    @(negedge clk);
    // Inputs wander after start; the packet in flight must ignore them.
    btype = 4'($urandom); data_idx = 4'($urandom); cache_info = rand_info(255);

    seen = 1'b0;
    for (int i = 0; i < plen + 40 && !seen; i++) begin
      if (fd_pack === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    t_fd = cyc;
    chk({tag, " fd_pack_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, t_fd - s, plen + 11);
    chk({tag, " write_count"}, wq.size(), plen + 9);

    nbad = 0; first_bad = -1;
    nwr = (wq.size() < exp_b.size()) ? wq.size() : exp_b.size();
    for (int i = 0; i < nwr; i++) begin
      if (wq[i].a !== base + 16'(i) || wq[i].d !== exp_b[i] ||
          wq[i].t != s + 1 + i + ((i >= 8) ? 1 : 0)) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk($sformatf("%s bytes(first_bad=%0d)", tag, first_bad), nbad, 0);

    erxa = {idx, 10'((plen > 0) ? plen - 1 : 0)};
    chk({tag, " tx_dlen"}, tx_dlen, plen + 9);
    chk({tag, " tx_addr_init"}, tx_addr_init, base);
    chk({tag, " txen_done"}, ram_txen, 1'b0);
    chk({tag, " cache_rxa_end"}, cache_rxa, erxa);
    chk({tag, " txa_hold"}, ram_txa, base + p16 + 16'd8);
    chk({tag, " txd_hold"}, ram_txd, x);

    hold_bad = 0;
    nwr = wq.size();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (fd_pack !== 1'b1) hold_bad++;
    end
    if (hold > 0) begin
      chk({tag, " fd_hold_bad"}, hold_bad, 0);
      chk({tag, " no_restart_writes"}, wq.size(), nwr);
    end

    fs_pack = 1'b0;
    @(negedge clk);
    chk({tag, " fd_release"}, fd_pack, 1'b0);
    exp_seq  = (exp_seq + 1) % 256;
    exp_base = exp_base ^ 1;
  endtask

  initial begin
    rst = 1'b1; fs_pack = 1'b0; btype = 4'd0; data_idx = 4'd0; cache_info = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst fd_pack", fd_pack, 1'b0);
    chk("rst ram_txen", ram_txen, 1'b0);
    chk("rst ram_txa", ram_txa, 16'h0);
    chk("rst ram_txd", ram_txd, 8'h0);
    chk("rst cache_rxa", cache_rxa, 14'h0);
    chk("rst tx_addr_init", tx_addr_init, 16'h0);
    chk("rst tx_dlen", tx_dlen, 16'h0);
    rst = 1'b0;

    // Abort a packet during BODY with an asynchronous reset.
    cache_info = rand_info(20);
    cache_info[8*5 +: 8] = 8'd50;
    @(negedge clk);
    btype = 4'd1; data_idx = 4'd5; fs_pack = 1'b1;
    repeat (14) @(negedge clk);
    chk("abort in_body", ram_txen, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort fd_pack", fd_pack, 1'b0);
    chk("abort ram_txen", ram_txen, 1'b0);
    chk("abort ram_txa", ram_txa, 16'h0);
    chk("abort ram_txd", ram_txd, 8'h0);
    chk("abort cache_rxa", cache_rxa, 14'h0);
    chk("abort tx_dlen", tx_dlen, 16'h0);
    chk("abort tx_addr_init", tx_addr_init, 16'h0);
    fs_pack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    exp_seq = 0; exp_base = 0;

    // Directed example: slot 2 holds one word, ramp payload.
    for (int k = 0; k < 4; k++) mem[{4'd2, 10'(k)}] = 8'(8'h11 * (k + 1));
    cache_info = rand_info(20);
    cache_info[8*2 +: 8] = 8'd1;
    run_pkt("p_dir", 4'd3, 4'd2, 0);

    // Ping/pong alternation; third packet also holds fs_pack past completion.
    cache_info = rand_info(20);
    run_pkt("p_pong", 4'($urandom), 4'($urandom_range(0, 11)), 0);
    cache_info = rand_info(20);
    run_pkt("p_ping_hold", 4'($urandom), 4'($urandom_range(0, 11)), 10);

    // Empty payloads: out-of-range slot and zero word count.
    cache_info = rand_info(20);
    run_pkt("p_idx13", 4'($urandom), 4'd13, 0);
    cache_info = rand_info(20);
    cache_info[8*7 +: 8] = 8'd0;
    run_pkt("p_zero", 4'($urandom), 4'd7, 0);

    // Largest payload.
    cache_info = rand_info(20);
    cache_info[8*9 +: 8] = 8'd255;
    run_pkt("p_max", 4'($urandom), 4'd9, 0);

    for (int r = 0; r < 6; r++) begin
      cache_info = rand_info(30);
      run_pkt($sformatf("p_rnd%0d", r), 4'($urandom), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
